calc1_port_responder: RTL

- Synthesizable single-port responder for the calc1 request/response protocol: the DUV side of one requester channel.
- Accepts a two-cycle request (command + operand1, then operand2), executes add/sub/shift-left/shift-right, and returns a one-cycle response code plus result.
- Used as a reference model next to calc1 ports and as a stand-in responder when bringing up requester-side benches.

---
 rtl/calc1_pkg.sv | 26 ++
 rtl/calc1_alu_core.sv | 63 ++++++
 rtl/calc1_port_responder.sv | 159 +++++++++++++++
 3 files changed

// File: rtl/calc1_pkg.sv
// Shared command/response codes, default width and FSM state encoding for calc1 ports.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package calc1_pkg;

  localparam int CALC1_DATA_W = 32;

  localparam logic [3:0] CMD_NONE = 4'd0;
  localparam logic [3:0] CMD_ADD  = 4'd1;
  localparam logic [3:0] CMD_SUB  = 4'd2;
  localparam logic [3:0] CMD_SHL  = 4'd5;
  localparam logic [3:0] CMD_SHR  = 4'd6;

  localparam logic [1:0] RESP_NONE = 2'd0;
  localparam logic [1:0] RESP_OK   = 2'd1;
  localparam logic [1:0] RESP_ERR  = 2'd2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_OPND2 = 3'd1,
    ST_EXEC  = 3'd2,
    ST_WAIT  = 3'd3,
    ST_RESP  = 3'd4
  } state_e;

endpackage

// File: rtl/calc1_alu_core.sv
// Combinational calc1 arithmetic: add/sub/shl/shr with error detection for one request.
// Latency: zero cycles (pure combinational).
// Backpressure: none; caller decides when to sample the result.
module calc1_alu_core
  import calc1_pkg::*;
#(
  parameter int DATA_W = CALC1_DATA_W
) (
  input  logic [3:0]        cmd,
  input  logic [0:DATA_W-1] op1,
  input  logic [0:DATA_W-1] op2,
  output logic [0:DATA_W-1] result,
  output logic [1:0]        resp
);

  // Operands re-expressed LSB-indexed so "low bits" read naturally below.
  logic [DATA_W-1:0] a;
  logic [DATA_W-1:0] b;
  logic [DATA_W:0]   sum;
  logic [4:0]        sh;

  assign a   = op1;
  assign b   = op2;
  assign sum = {1'b0, a} + {1'b0, b};
  assign sh  = b[4:0];

  // Select the operation; any error forces a zero result.
  always_comb begin
    result = '0;
    resp   = RESP_ERR;
    case (cmd)
      CMD_ADD: begin
        if (sum[DATA_W]) begin
          resp = RESP_ERR;
        end else begin
          resp   = RESP_OK;
          result = sum[DATA_W-1:0];
        end
      end
      CMD_SUB: begin
        if (b > a) begin
          resp = RESP_ERR;
        end else begin
          resp   = RESP_OK;
          result = a - b;
        end
      end
      CMD_SHL: begin
        resp   = RESP_OK;
        result = a << sh;
      end
      CMD_SHR: begin
        resp   = RESP_OK;
        result = a >> sh;
      end
      default: begin
        resp   = RESP_ERR;
        result = '0;
      end
    endcase
  end

endmodule

// File: rtl/calc1_port_responder.sv
// Single-port calc1 responder: two-cycle request in, one-cycle response out.
// Latency: response registered RESP_LAT edges after the command-sample edge.
// Backpressure: none; commands arriving while not idle are dropped and flagged in drop_err.
module calc1_port_responder
  import calc1_pkg::*;
#(
  parameter int DATA_W   = CALC1_DATA_W,
  parameter int RESP_LAT = 3
) (
  input  logic              c_clk,
  input  logic              reset,
  input  logic [3:0]        req_cmd_in,
  input  logic [0:DATA_W-1] req_data_in,
  output logic [1:0]        out_resp,
  output logic [0:DATA_W-1] out_data,
  output logic              busy,
  output logic              drop_err
);

  // Cycles spent in WAIT; EXEC and RESP already account for three edges.
  localparam logic [3:0] WAIT_CNT = 4'(RESP_LAT - 3);

  state_e            state_q;
  state_e            state_d;
  logic [3:0]        cmd_q;
  logic [0:DATA_W-1] op1_q;
  logic [0:DATA_W-1] op2_q;
  logic [0:DATA_W-1] res_q;
  logic [1:0]        rsp_q;
  logic [3:0]        cnt_q;

  logic [0:DATA_W-1] alu_result;
  logic [1:0]        alu_resp;

  logic latch_cmd;
  logic latch_op2;
  logic do_exec;
  logic dec_cnt;
  logic load_out;
  logic clear_out;
  logic drop;

  calc1_alu_core #(
    .DATA_W (DATA_W)
  ) u_alu (
    .cmd    (cmd_q),
    .op1    (op1_q),
    .op2    (op2_q),
    .result (alu_result),
    .resp   (alu_resp)
  );

  // State register.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and datapath strobes; RESP spans two cycles, the second being the response cycle.
  always_comb begin
    state_d   = state_q;
    latch_cmd = 1'b0;
    latch_op2 = 1'b0;
    do_exec   = 1'b0;
    dec_cnt   = 1'b0;
    load_out  = 1'b0;
    clear_out = 1'b0;
    drop      = (state_q != ST_IDLE) && (req_cmd_in != CMD_NONE);
    case (state_q)
      ST_IDLE: begin
        if (req_cmd_in != CMD_NONE) begin
          latch_cmd = 1'b1;
          state_d   = ST_OPND2;
        end
      end
      ST_OPND2: begin
        latch_op2 = 1'b1;
        state_d   = ST_EXEC;
      end
      ST_EXEC: begin
        do_exec = 1'b1;
        state_d = (WAIT_CNT == 4'd0) ? ST_RESP : ST_WAIT;
      end
      ST_WAIT: begin
        dec_cnt = 1'b1;
        if (cnt_q == 4'd1) begin
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (out_resp == RESP_NONE) begin
          load_out = 1'b1;
        end else begin
          clear_out = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // Request capture, execution holding register and latency counter.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      cmd_q <= CMD_NONE;
      op1_q <= '0;
      op2_q <= '0;
      res_q <= '0;
      rsp_q <= RESP_NONE;
      cnt_q <= '0;
    end else begin
      if (latch_cmd) begin
        cmd_q <= req_cmd_in;
        op1_q <= req_data_in;
      end
      if (latch_op2) begin
        op2_q <= req_data_in;
      end
      if (do_exec) begin
        res_q <= alu_result;
        rsp_q <= alu_resp;
        cnt_q <= WAIT_CNT;
      end else if (dec_cnt) begin
        cnt_q <= cnt_q - 4'd1;
      end
    end
  end

  // Registered outputs: one-cycle response pulse, busy window and sticky drop flag.
  always_ff @(posedge c_clk) begin
    if (reset) begin
      out_resp <= RESP_NONE;
      out_data <= '0;
      busy     <= 1'b0;
      drop_err <= 1'b0;
    end else begin
      if (latch_cmd) begin
        busy <= 1'b1;
      end
      if (load_out) begin
        out_resp <= rsp_q;
        out_data <= res_q;
      end else if (clear_out) begin
        out_resp <= RESP_NONE;
        out_data <= '0;
        busy     <= 1'b0;
      end
      if (drop) begin
        drop_err <= 1'b1;
      end
    end
  end

endmodule
